flag_unit: RTL and testbench
============================

# flag_unit

- Holds the CPU status flags (Zero, Carry, Negative), updated from the ALU's combinational flag outputs under control-unit command.
- Supplies the registered carry back to the ALU as its carry-in for ADC/SBC.
- Evaluates jump conditions for the control unit.
- Provides a small LIFO of saved flag states for CALL/interrupt entry and exit.

## Interface
Parameters:
- STACK_DEPTH, 4 — number of flag snapshots the LIFO holds (power of two, 2..16).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- alu_zero, alu_carry, alu_negative  input  1 each  combinational flags from the ALU for the current operation.
- flag_op  input  3  flag_op_t command, one per cycle.
- data_in  input  DATA_WIDTH  packed flags for FLAG_RESTORE (bit0 Z, bit1 C, bit2 N; upper bits ignored).
- cond_sel  input  3  cond_t selector for jump evaluation.
- zero_flag, carry_flag, negative_flag  output  1 each  registered flags; carry_flag also drives the ALU carry-in.
- flags_packed  output  DATA_WIDTH  {zeros, N, C, Z}.
- cond_true  output  1  combinational result of cond_sel against the registered flags.
- stack_full, stack_empty  output  1 each  LIFO status.
- stack_error  output  1  sticky; set on push-when-full or pop-when-empty.

## Operation
- Reset (asynchronous assert) sets all flags to 0, stack pointer to 0, and stack_error to 0.
  - Outputs during reset: stack_empty=1, stack_full=0, flags_packed=0.
- flag_op encodings:
  - FLAG_NOP: hold all state.
  - FLAG_LOAD: Z, C, N <= alu_zero, alu_carry, alu_negative.
  - FLAG_SEC: C <= 1; Z and N unchanged.
  - FLAG_CLC: C <= 0; Z and N unchanged.
  - FLAG_CMC: C <= ~C.
  - FLAG_RESTORE: Z, C, N <= data_in[0], data_in[1], data_in[2].
  - FLAG_PUSH: stack[sp] <= current packed flags; sp <= sp + 1. Flags unchanged.
  - FLAG_POP: flags <= stack[sp-1]; sp <= sp - 1.
- Boundary cases:
  - PUSH when full: no write, sp unchanged, stack_error <= 1.
  - POP when empty: flags unchanged, sp unchanged, stack_error <= 1.
- sp ranges 0..STACK_DEPTH and never wraps.
  - stack_full = (sp == STACK_DEPTH).
  - stack_empty = (sp == 0).
- Only one command is possible per cycle by encoding, so there are no simultaneous-operation cases.
- stack_error clears only on reset.
- cond_sel encodings and results:
  - COND_ALWAYS = 1
  - COND_Z = Z
  - COND_NZ = ~Z
  - COND_C = C
  - COND_NC = ~C
  - COND_N = N
  - COND_P = ~N
  - COND_NEVER = 0
- Carry convention matches the ALU: C=1 on subtract means no borrow. COND_NC therefore means "A < B unsigned" after SUB/CMP.

## Timing
- All commands take effect at the next rising clk edge, with single-cycle latency.
- FLAG_LOAD samples the ALU flags in the same cycle the ALU computes the operation. The ALU latches its result on that same edge.
- cond_true, flags_packed, stack_full and stack_empty are combinational from registered state only. cond_sel has a combinational path to cond_true.
- Consequence: a jump in cycle N+1 sees flags loaded at the edge ending cycle N.
- ALU carry-in during cycle N is carry_flag as registered before edge N. ADC followed immediately by FLAG_LOAD therefore consumes the old carry.
- PUSH stores the flags as they were before the edge.
- Reset asserted mid-operation discards the pending command. The first command after deassertion is taken on the first clean edge.

## Configuration
- FLAG_STACK_EN defined: the LIFO is present as described above.
- FLAG_STACK_EN undefined: FLAG_PUSH and FLAG_POP behave as FLAG_NOP. Outputs are tied to stack_full=0, stack_empty=1, stack_error=0.
- STACK_DEPTH is ignored when FLAG_STACK_EN is undefined, and no storage is inferred.

## Structure
- arch_defs_pkg gains:
  - flag_op_t enum (3 bits: NOP, LOAD, SEC, CLC, CMC, RESTORE, PUSH, POP).
  - cond_t enum (3 bits, order as listed in Operation).
  - FLAG_Z_BIT=0, FLAG_C_BIT=1, FLAG_N_BIT=2, FLAG_WIDTH=3.
- One sub-module, flag_stack: a parameterised LIFO with push/pop/full/empty/error and the same reset. It is instantiated only under FLAG_STACK_EN.

## Test plan
- Reset then FLAG_LOAD with alu flags Z=1,C=0,N=1 -> flags_packed=0x05 next cycle; cond_sel=COND_Z gives cond_true=1; COND_NC gives cond_true=1.
- SEC, then CMC, then CLC with Z=1 held -> C sequence 1,0,0; Z stays 1 throughout; flags_packed 0x03, 0x01, 0x01.
- STACK_DEPTH=4: RESTORE 0x01, PUSH; RESTORE 0x02, PUSH; RESTORE 0x04; then POP, POP -> flags 0x02 then 0x01; stack_empty=1; stack_error=0.
- 5 PUSHes from empty -> stack_full=1 after the 4th; 5th sets stack_error=1; 4 POPs return 4 entries, then a 5th POP leaves flags unchanged and stack_empty=1.
- Assert reset asynchronously mid-cycle with sp=3 and flags=0x07 -> all outputs clear before the next edge; stack_error=0.
- Build without FLAG_STACK_EN: PUSH/POP leave flags and status unchanged (stack_empty=1, stack_full=0, stack_error=0); cond evaluation is unaffected.

Source files
------------

// File: rtl/arch_defs_pkg.sv
// -----------------------------------------------------------------------------
// arch_defs_pkg
// Shared architectural definitions for the CPU flag logic.
//   - DATA_WIDTH   : width of the CPU data path (packed flags, restore data)
//   - FLAG_*_BIT   : bit positions of Z, C, N inside a packed flag word
//   - flag_op_t    : flag-unit command issued by the control unit each cycle
//   - cond_t       : jump-condition selector
//   - pack_flags() : builds a packed {N, C, Z} flag word
//   - eval_cond()  : evaluates a jump condition against a packed flag word
// -----------------------------------------------------------------------------
package arch_defs_pkg;

    localparam int DATA_WIDTH = 8;

    localparam int FLAG_Z_BIT = 0;
    localparam int FLAG_C_BIT = 1;
    localparam int FLAG_N_BIT = 2;
    localparam int FLAG_WIDTH = 3;

    typedef enum logic [2:0] {
        FLAG_NOP     = 3'd0,
        FLAG_LOAD    = 3'd1,
        FLAG_SEC     = 3'd2,
        FLAG_CLC     = 3'd3,
        FLAG_CMC     = 3'd4,
        FLAG_RESTORE = 3'd5,
        FLAG_PUSH    = 3'd6,
        FLAG_POP     = 3'd7
    } flag_op_t;

    // C=1 after SUB/CMP means "no borrow", so COND_NC is the unsigned A < B test.
    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_Z      = 3'd1,
        COND_NZ     = 3'd2,
        COND_C      = 3'd3,
        COND_NC     = 3'd4,
        COND_N      = 3'd5,
        COND_P      = 3'd6,
        COND_NEVER  = 3'd7
    } cond_t;

    function automatic logic [FLAG_WIDTH-1:0] pack_flags(
        input logic z,
        input logic c,
        input logic n
    );
        logic [FLAG_WIDTH-1:0] f;
        f             = '0;
        f[FLAG_Z_BIT] = z;
        f[FLAG_C_BIT] = c;
        f[FLAG_N_BIT] = n;
        return f;
    endfunction

    function automatic logic eval_cond(
        input cond_t                 sel,
        input logic [FLAG_WIDTH-1:0] f
    );
        logic r;
        case (sel)
            COND_ALWAYS: r = 1'b1;
            COND_Z:      r = f[FLAG_Z_BIT];
            COND_NZ:     r = ~f[FLAG_Z_BIT];
            COND_C:      r = f[FLAG_C_BIT];
            COND_NC:     r = ~f[FLAG_C_BIT];
            COND_N:      r = f[FLAG_N_BIT];
            COND_P:      r = ~f[FLAG_N_BIT];
            COND_NEVER:  r = 1'b0;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage : arch_defs_pkg

// File: rtl/flag_stack.sv
// -----------------------------------------------------------------------------
// flag_stack
// Small LIFO of saved flag words used on CALL / interrupt entry and exit.
// The stack pointer counts 0..DEPTH and never wraps; an overflowing push or an
// underflowing pop is dropped and latches a sticky error until reset.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (clears pointer and error)
//   i_push   : store i_data on top of stack
//   i_pop    : remove the top entry (its value is presented on o_top)
//   i_data   : flag word to push
//   o_top    : current top entry (valid when o_empty is 0)
//   o_full   : pointer equals DEPTH
//   o_empty  : pointer equals 0
//   o_error  : sticky overflow/underflow indication
// -----------------------------------------------------------------------------
module flag_stack
    import arch_defs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = FLAG_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_error
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_sp;
    logic             r_error;

    logic [PTR_W-1:0] w_sp_m1;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_sp == PTR_W'(DEPTH));
    assign w_empty   = (r_sp == {PTR_W{1'b0}});
    assign w_sp_m1   = r_sp - {{(PTR_W-1){1'b0}}, 1'b1};
    assign w_wr_idx  = r_sp[IDX_W-1:0];
    assign w_rd_idx  = w_sp_m1[IDX_W-1:0];
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~w_empty;

    // Storage array: cleared on reset, written only by an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

    // Stack pointer: saturates at 0 and DEPTH instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= {PTR_W{1'b0}};
        end else if (w_do_push) begin
            r_sp <= r_sp + {{(PTR_W-1){1'b0}}, 1'b1};
        end else if (w_do_pop) begin
            r_sp <= w_sp_m1;
        end
    end

    // Sticky error: set by a rejected push or pop, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_error <= 1'b0;
        end else if ((i_push & w_full) | (i_pop & w_empty)) begin
            r_error <= 1'b1;
        end
    end

    assign o_top   = r_mem[w_rd_idx];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_error = r_error;

endmodule : flag_stack

// File: rtl/flag_unit.sv
// -----------------------------------------------------------------------------
// flag_unit
// CPU status-flag register (Zero, Carry, Negative) with jump-condition
// evaluation and an optional LIFO of saved flag states.
// Build option: define FLAG_STACK_EN to include the flag stack; without it
// FLAG_PUSH/FLAG_POP act as FLAG_NOP and the stack status is tied off
// (stack_full=0, stack_empty=1, stack_error=0) with no storage.
// Ports:
//   clk, reset            : clock and asynchronous active-low reset
//   alu_zero/carry/negative : combinational ALU flags for the current op
//   flag_op               : flag_op_t command for this cycle
//   data_in               : packed flags for FLAG_RESTORE (bit0 Z, bit1 C, bit2 N)
//   cond_sel              : cond_t jump-condition selector
//   zero/carry/negative_flag : registered flags (carry_flag feeds ALU carry-in)
//   flags_packed          : {zeros, N, C, Z}
//   cond_true             : cond_sel evaluated against the registered flags
//   stack_full/empty/error : flag-stack status
// -----------------------------------------------------------------------------
module flag_unit
    import arch_defs_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_zero,
    input  logic                  alu_carry,
    input  logic                  alu_negative,
    input  logic [2:0]            flag_op,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [2:0]            cond_sel,
    output logic                  zero_flag,
    output logic                  carry_flag,
    output logic                  negative_flag,
    output logic [DATA_WIDTH-1:0] flags_packed,
    output logic                  cond_true,
    output logic                  stack_full,
    output logic                  stack_empty,
    output logic                  stack_error
);

    flag_op_t              w_op;
    logic [FLAG_WIDTH-1:0] r_flags;
    logic [FLAG_WIDTH-1:0] w_flags_nxt;
    logic                  w_push;
    logic                  w_pop;
    logic [FLAG_WIDTH-1:0] w_stack_top;
    logic                  w_stack_full;
    logic                  w_stack_empty;
    logic                  w_stack_error;

    assign w_op   = flag_op_t'(flag_op);
    assign w_push = (w_op == FLAG_PUSH);
    assign w_pop  = (w_op == FLAG_POP);

`ifdef FLAG_STACK_EN
    // Push stores the flags as they were before the edge (r_flags).
    flag_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (FLAG_WIDTH)
    ) u_flag_stack (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_flags),
        .o_top   (w_stack_top),
        .o_full  (w_stack_full),
        .o_empty (w_stack_empty),
        .o_error (w_stack_error)
    );
`else
    // No stack: an always-empty status makes FLAG_POP hold the flags.
    assign w_stack_top   = '0;
    assign w_stack_full  = 1'b0;
    assign w_stack_empty = 1'b1;
    assign w_stack_error = 1'b0;

    logic w_unused_stack;
    assign w_unused_stack = ^{w_push, w_pop, STACK_DEPTH[0]};
`endif

    // Only the low flag bits of data_in are meaningful for FLAG_RESTORE.
    logic w_unused_data;
    assign w_unused_data = ^data_in[DATA_WIDTH-1:FLAG_WIDTH];

    // Next-state flag decode, one command per cycle.
    always_comb begin
        w_flags_nxt = r_flags;
        case (w_op)
            FLAG_NOP:     w_flags_nxt = r_flags;
            FLAG_LOAD:    w_flags_nxt = pack_flags(alu_zero, alu_carry, alu_negative);
            FLAG_SEC:     w_flags_nxt[FLAG_C_BIT] = 1'b1;
            FLAG_CLC:     w_flags_nxt[FLAG_C_BIT] = 1'b0;
            FLAG_CMC:     w_flags_nxt[FLAG_C_BIT] = ~r_flags[FLAG_C_BIT];
            FLAG_RESTORE: w_flags_nxt = data_in[FLAG_WIDTH-1:0];
            FLAG_PUSH:    w_flags_nxt = r_flags;
            FLAG_POP: begin
                // Underflowing pop leaves the flags untouched.
                if (!w_stack_empty) begin
                    w_flags_nxt = w_stack_top;
                end else begin
                    w_flags_nxt = r_flags;
                end
            end
            default:      w_flags_nxt = r_flags;
        endcase
    end

    // Flag register: reset discards any pending command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= {FLAG_WIDTH{1'b0}};
        end else begin
            r_flags <= w_flags_nxt;
        end
    end

    assign zero_flag     = r_flags[FLAG_Z_BIT];
    assign carry_flag    = r_flags[FLAG_C_BIT];
    assign negative_flag = r_flags[FLAG_N_BIT];
    assign flags_packed  = {{(DATA_WIDTH-FLAG_WIDTH){1'b0}}, r_flags};
    assign cond_true     = eval_cond(cond_t'(cond_sel), r_flags);
    assign stack_full    = w_stack_full;
    assign stack_empty   = w_stack_empty;
    assign stack_error   = w_stack_error;

endmodule : flag_unit

// File: tb/tb_flag_unit.sv
// Directed self-checking bench for flag_unit. Stack scenarios are selected by
// FLAG_STACK_EN so the same bench covers both builds.
module tb_flag_unit;
    import arch_defs_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       alu_zero, alu_carry, alu_negative;
    logic [2:0] flag_op;
    logic [7:0] data_in;
    logic [2:0] cond_sel;
    logic       zero_flag, carry_flag, negative_flag;
    logic [7:0] flags_packed;
    logic       cond_true;
    logic       stack_full, stack_empty, stack_error;

    int checks   = 0;
    int failures = 0;

    flag_unit #(.STACK_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .alu_zero      (alu_zero),
        .alu_carry     (alu_carry),
        .alu_negative  (alu_negative),
        .flag_op       (flag_op),
        .data_in       (data_in),
        .cond_sel      (cond_sel),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .negative_flag (negative_flag),
        .flags_packed  (flags_packed),
        .cond_true     (cond_true),
        .stack_full    (stack_full),
        .stack_empty   (stack_empty),
        .stack_error   (stack_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one command on the falling edge; return just after the rising edge.
    task automatic apply(input logic [2:0] op, input logic [7:0] d);
        @(negedge clk);
        flag_op = op;
        data_in = d;
        @(posedge clk);
        #1;
        flag_op = 3'(FLAG_NOP);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flag_op = 3'(FLAG_NOP); data_in = 8'h00; cond_sel = 3'(COND_ALWAYS);
        alu_zero = 1'b0; alu_carry = 1'b0; alu_negative = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (flags_packed !== 8'h00) begin failures++; $display("FAIL reset_flags got=%h exp=00", flags_packed); end
        checks++; if ({stack_full, stack_empty, stack_error} !== 3'b010) begin failures++; $display("FAIL reset_status got=%b exp=010", {stack_full, stack_empty, stack_error}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        logic [7:0] exp_conds [2];
        logic [7:0] row;
        exp_conds[0] = 8'h33;  // flags Z=1 C=0 N=1
        exp_conds[1] = 8'h4D;  // flags Z=0 C=1 N=0
        alu_zero = 1'b1; alu_carry = 1'b0; alu_negative = 1'b1;
        apply(3'(FLAG_LOAD), 8'h00);
        alu_zero = 1'b0; alu_carry = 1'b1; alu_negative = 1'b0;
        checks++; if (flags_packed !== 8'h05) begin failures++; $display("FAIL load_packed got=%h exp=05", flags_packed); end
        checks++; if ({negative_flag, carry_flag, zero_flag} !== 3'b101) begin failures++; $display("FAIL load_bits got=%b exp=101", {negative_flag, carry_flag, zero_flag}); end
        for (int p = 0; p < 2; p++) begin
            if (p == 1) begin
                apply(3'(FLAG_LOAD), 8'h00);
                checks++; if (flags_packed !== 8'h02) begin failures++; $display("FAIL load2_packed got=%h exp=02", flags_packed); end
            end
            row = exp_conds[p];
            for (int c = 0; c < 8; c++) begin
                cond_sel = 3'(c);
                #1;
                checks++; if (cond_true !== row[c]) begin failures++; $display("FAIL cond p=%0d sel=%0d got=%b exp=%b", p, c, cond_true, row[c]); end
            end
        end
        // NOP holds despite changing ALU flags
        alu_zero = 1'b1; alu_carry = 1'b0; alu_negative = 1'b1;
        apply(3'(FLAG_NOP), 8'hFF);
        checks++; if (flags_packed !== 8'h02) begin failures++; $display("FAIL nop_hold got=%h exp=02", flags_packed); end
    endtask

    task automatic test_carry_ops();
        // Upper data_in bits must be ignored
        apply(3'(FLAG_RESTORE), 8'hF9);
        checks++; if (flags_packed !== 8'h01) begin failures++; $display("FAIL restore_mask got=%h exp=01", flags_packed); end
        apply(3'(FLAG_SEC), 8'h00);
        checks++; if (flags_packed !== 8'h03 || carry_flag !== 1'b1) begin failures++; $display("FAIL sec got=%h exp=03", flags_packed); end
        apply(3'(FLAG_CMC), 8'h00);
        checks++; if (flags_packed !== 8'h01 || carry_flag !== 1'b0) begin failures++; $display("FAIL cmc got=%h exp=01", flags_packed); end
        apply(3'(FLAG_CLC), 8'h00);
        checks++; if (flags_packed !== 8'h01) begin failures++; $display("FAIL clc got=%h exp=01", flags_packed); end
        apply(3'(FLAG_CMC), 8'h00);
        checks++; if (flags_packed !== 8'h03) begin failures++; $display("FAIL cmc_set got=%h exp=03", flags_packed); end
        apply(3'(FLAG_RESTORE), 8'h06);
        apply(3'(FLAG_CLC), 8'h00);
        checks++; if (flags_packed !== 8'h04) begin failures++; $display("FAIL clc_keep_n got=%h exp=04", flags_packed); end
    endtask

`ifdef FLAG_STACK_EN
    task automatic test_stack();
        apply(3'(FLAG_RESTORE), 8'h01);
        apply(3'(FLAG_PUSH), 8'h00);
        checks++; if (flags_packed !== 8'h01 || stack_empty !== 1'b0) begin failures++; $display("FAIL push1 got=%h empty=%b exp=01 empty=0", flags_packed, stack_empty); end
        apply(3'(FLAG_RESTORE), 8'h02);
        apply(3'(FLAG_PUSH), 8'h00);
        apply(3'(FLAG_RESTORE), 8'h04);
        checks++; if (stack_full !== 1'b0) begin failures++; $display("FAIL two_not_full got=%b exp=0", stack_full); end
        apply(3'(FLAG_POP), 8'h00);
        checks++; if (flags_packed !== 8'h02) begin failures++; $display("FAIL pop1 got=%h exp=02", flags_packed); end
        apply(3'(FLAG_POP), 8'h00);
        checks++; if (flags_packed !== 8'h01) begin failures++; $display("FAIL pop2 got=%h exp=01", flags_packed); end
        checks++; if ({stack_empty, stack_error} !== 2'b10) begin failures++; $display("FAIL pop_status got=%b exp=10", {stack_empty, stack_error}); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) begin
            apply(3'(FLAG_RESTORE), 8'(i));
            apply(3'(FLAG_PUSH), 8'h00);
            checks++; if (stack_full !== (i == 4)) begin failures++; $display("FAIL full_after_push%0d got=%b", i, stack_full); end
        end
        checks++; if (stack_error !== 1'b0) begin failures++; $display("FAIL err_before_ovf got=%b exp=0", stack_error); end
        apply(3'(FLAG_RESTORE), 8'h05);
        apply(3'(FLAG_PUSH), 8'h00);
        checks++; if ({stack_full, stack_error} !== 2'b11 || flags_packed !== 8'h05) begin failures++; $display("FAIL overflow got=%b/%h exp=11/05", {stack_full, stack_error}, flags_packed); end
        for (int i = 4; i >= 1; i--) begin
            apply(3'(FLAG_POP), 8'h00);
            checks++; if (flags_packed !== 8'(i)) begin failures++; $display("FAIL pop_seq got=%h exp=%h", flags_packed, 8'(i)); end
        end
        checks++; if (stack_empty !== 1'b1) begin failures++; $display("FAIL empty_after_pops got=%b exp=1", stack_empty); end
        apply(3'(FLAG_POP), 8'h00);
        checks++; if (flags_packed !== 8'h01 || stack_empty !== 1'b1 || stack_error !== 1'b1) begin failures++; $display("FAIL underflow got=%h e=%b err=%b exp=01 1 1", flags_packed, stack_empty, stack_error); end
    endtask
`else
    task automatic test_stack_disabled();
        apply(3'(FLAG_RESTORE), 8'h06);
        apply(3'(FLAG_PUSH), 8'h00);
        checks++; if (flags_packed !== 8'h06) begin failures++; $display("FAIL nostk_push got=%h exp=06", flags_packed); end
        checks++; if ({stack_full, stack_empty, stack_error} !== 3'b010) begin failures++; $display("FAIL nostk_status got=%b exp=010", {stack_full, stack_empty, stack_error}); end
        apply(3'(FLAG_RESTORE), 8'h03);
        apply(3'(FLAG_POP), 8'h00);
        checks++; if (flags_packed !== 8'h03) begin failures++; $display("FAIL nostk_pop got=%h exp=03", flags_packed); end
        checks++; if ({stack_full, stack_empty, stack_error} !== 3'b010) begin failures++; $display("FAIL nostk_status2 got=%b exp=010", {stack_full, stack_empty, stack_error}); end
        cond_sel = 3'(COND_NZ);
        #1;
        checks++; if (cond_true !== 1'b0) begin failures++; $display("FAIL nostk_cond got=%b exp=0", cond_true); end
    endtask
`endif

    task automatic test_async_reset();
`ifdef FLAG_STACK_EN
        for (int i = 0; i < 3; i++) apply(3'(FLAG_PUSH), 8'h00);
        checks++; if ({stack_full, stack_empty} !== 2'b00) begin failures++; $display("FAIL sp3_status got=%b exp=00", {stack_full, stack_empty}); end
`endif
        apply(3'(FLAG_RESTORE), 8'h07);
        checks++; if (flags_packed !== 8'h07) begin failures++; $display("FAIL pre_reset got=%h exp=07", flags_packed); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (flags_packed !== 8'h00 || {stack_full, stack_empty, stack_error} !== 3'b010) begin failures++; $display("FAIL async_reset got=%h/%b exp=00/010", flags_packed, {stack_full, stack_empty, stack_error}); end
        // A command presented during reset must be discarded
        flag_op = 3'(FLAG_LOAD);
        alu_zero = 1'b1; alu_carry = 1'b1; alu_negative = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (flags_packed !== 8'h00) begin failures++; $display("FAIL reset_discard got=%h exp=00", flags_packed); end
        @(negedge clk);
        flag_op = 3'(FLAG_NOP);
        rst_n = 1'b1;
        apply(3'(FLAG_LOAD), 8'h00);
        checks++; if (flags_packed !== 8'h07) begin failures++; $display("FAIL post_reset_load got=%h exp=07", flags_packed); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_carry_ops();
`ifdef FLAG_STACK_EN
        test_stack();
        test_overflow();
`else
        test_stack_disabled();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_flag_unit
